operand_fetch: RTL

Operand-fetch stage of the CPU datapath, sitting directly upstream of the ALU. It holds the 32×32 general register file and an ID→EX pipeline register. It reads `rs`/`rt`, selects immediate or shift-amount operands, and presents registered `alu_a`, `alu_b` and `aluc` to the ALU under a valid/ready handshake. Writeback from the end of the pipeline enters through a dedicated write port.

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/regfile32.sv | 55 +++++
 rtl/operand_fetch.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: ALU opcodes, register constants, ID->EX bundle.
package cpu_pkg;

    localparam int DW = 32;
    localparam int NREG = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_AND = 4'b0001,
        ALU_XOR = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SUB = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_LUI = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1111
    } alu_op_e;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    aluc;
        logic [4:0]    rd;
        logic          wreg;
    } id_ex_t;

    function automatic logic [DW-1:0] shamt_ext(input logic [DW-1:0] imm);
        return {{(DW-5){1'b0}}, imm[10:6]};
    endfunction

endpackage

// File: rtl/regfile32.sv
// 2R1W general register file, R0 hardwired to zero.
// OPF_WB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile32
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int NREG = cpu_pkg::NREG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    ra_idx,
    input  logic [4:0]    rb_idx,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    input  logic          we,
    input  logic [4:0]    wr_idx,
    input  logic [DW-1:0] wr_data
);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          hit_a;
    logic          hit_b;

    always_comb begin
        regs_d = regs_q;
        if (we && wr_idx != REG_ZERO) begin
            regs_d[wr_idx] = wr_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef OPF_WB_BYPASS_EN
    assign hit_a = we && (wr_idx == ra_idx);
    assign hit_b = we && (wr_idx == rb_idx);
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    // Index 0 check comes first so a bypass hit on R0 still reads zero.
    assign ra_data = (ra_idx == REG_ZERO) ? '0 :
                     hit_a ? wr_data : regs_q[ra_idx];
    assign rb_data = (rb_idx == REG_ZERO) ? '0 :
                     hit_b ? wr_data : regs_q[rb_idx];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: regfile read, operand select, ID->EX register.
// Optional same-cycle writeback bypass: OPF_WB_BYPASS_EN.
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int NREG = cpu_pkg::NREG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [DW-1:0] in_imm,
    input  logic          in_sel_a,
    input  logic          in_sel_b,
    input  logic [3:0]    in_aluc,
    input  logic          in_wreg,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    aluc,
    output logic [4:0]    out_rd,
    output logic          out_wreg,
    input  logic          wb_we,
    input  logic [4:0]    wb_rd,
    input  logic [DW-1:0] wb_data
);

    typedef enum logic {EMPTY, FULL} state_e;

    state_e        state_q;
    state_e        state_d;
    id_ex_t        pipe_q;
    id_ex_t        pipe_d;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic          accept;

    regfile32 #(.DW(DW), .NREG(NREG)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .ra_idx  (in_rs),
        .rb_idx  (in_rt),
        .ra_data (rs_data),
        .rb_data (rt_data),
        .we      (wb_we),
        .wr_idx  (wb_rd),
        .wr_data (wb_data)
    );

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        state_d = state_q;
        pipe_d  = pipe_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (flush) begin
                    state_d = EMPTY;
                end else if (!accept && out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Data is only loaded on accept; consume and flush leave it as-is.
        if (accept) begin
            pipe_d.a    = in_sel_a ? shamt_ext(in_imm) : rs_data;
            pipe_d.b    = in_sel_b ? in_imm : rt_data;
            pipe_d.aluc = in_aluc;
            pipe_d.rd   = in_rd;
            pipe_d.wreg = in_wreg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            pipe_q  <= pipe_d;
        end
    end

    assign alu_a    = pipe_q.a;
    assign alu_b    = pipe_q.b;
    assign aluc     = pipe_q.aluc;
    assign out_rd   = pipe_q.rd;
    assign out_wreg = pipe_q.wreg;

endmodule
